inc_burst_sequencer: RTL

Upstream stage for the 32-bit step-by-3 register. It accepts a burst request over a valid/ready handshake and turns it into a paced train of single-cycle `inc` pulses on the register's `inc` input. Pulse count and inter-pulse gap come with each request. An abort input and a wrapping lifetime pulse counter are included so the controller above can stop a burst early and audit what was issued.

---
 rtl/inc_burst_sequencer_if.sv | 13 +
 rtl/inc_burst_sequencer.sv | 108 ++++++++++
 2 files changed

// File: rtl/inc_burst_sequencer_if.sv
// Burst request channel: valid/ready handshake carrying pulse count and inter-pulse gap.
interface inc_burst_sequencer_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [CNT_W-1:0] req_count;
  logic [GAP_W-1:0] req_gap;

  modport master (output req_valid, output req_count, output req_gap, input req_ready);
  modport slave  (input req_valid, input req_count, input req_gap, output req_ready);
endinterface

// File: rtl/inc_burst_sequencer.sv
// Turns an accepted burst request into a paced train of single-cycle inc pulses
// for the step-by-3 register, with abort and a wrapping lifetime pulse counter.
module inc_burst_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4,
  parameter int unsigned ISS_W = 16
) (
  input  logic                 clock,
  input  logic                 clear_n,
  inc_burst_sequencer_if.slave req,
  input  logic                 abort,
  output logic                 inc,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [ISS_W-1:0]     issued
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [ISS_W-1:0]   issued_d;
  logic               aborted_d;
  logic               ready_q;

  assign req.req_ready = ready_q;

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    issued_d  = issued;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          remain_d = req.req_count;
          gap_d    = req.req_gap;
          state_d  = (req.req_count == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        remain_d = remain_q - CNT_W'(1);
        issued_d = issued + ISS_W'(1);
        // The final pulse completes normally even if abort arrives with it
        if (remain_q == CNT_W'(1)) begin
          state_d = DONE;
        end else if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (gap_q == '0) begin
          state_d = PULSE;
        end else begin
          state_d   = GAP;
          gap_cnt_d = gap_q;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = PULSE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; outputs are flopped from the next-state decode
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      remain_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      issued    <= '0;
      aborted   <= 1'b0;
      inc       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      issued    <= issued_d;
      aborted   <= aborted_d;
      inc       <= (state_d == PULSE);
      busy      <= (state_d == PULSE) || (state_d == GAP);
      done      <= (state_d == DONE);
      ready_q   <= (state_d == IDLE);
    end
  end

endmodule
